// File: rtl/vc_pkg.sv
// Shared types and helpers for the L1 victim-cache requester.
// Line geometry, FSM state encoding and line alignment.
package vc_pkg;

    localparam int S_OFFSET = 5;
    localparam int S_LINE   = 256;
    localparam int ADDR_W   = 32;

    typedef logic [S_LINE-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        VC_RD,
        PMEM_RD,
        VC_WR,
        FILL
    } l1vc_state_t;

    // Clear the byte-offset bits so every request names a whole line.
    function automatic addr_t align_line(addr_t a);
        return {a[ADDR_W-1:S_OFFSET], {S_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/l1_vc_requester_if.sv
// Signal bundle between L1, the victim cache and lower memory.
// master = requester side, slave = L1/VC/memory side.
interface l1_vc_requester_if;
    import vc_pkg::*;

    logic  l1_miss_req;
    logic  l1_evict;
    addr_t l1_miss_addr;
    addr_t l1_victim_addr;
    line_t l1_victim_data;
    logic  l1_victim_dirty;
    line_t l1_fill_data;
    logic  l1_fill_valid;
    logic  l1_fill_from_vc;
    logic  busy;
    addr_t mem_address;
    logic  vc_read;
    logic  vc_write;
    line_t mem_wdata;
    logic  is_mem_wdata_dirty;
    line_t vc_vcmem_rdata256;
    logic  rdata_exists;
    logic  pmem_read;
    addr_t pmem_address;
    line_t pmem_rdata;
    logic  pmem_resp;

    modport master (
        input  l1_miss_req, l1_evict, l1_miss_addr,
        input  l1_victim_addr, l1_victim_data, l1_victim_dirty,
        output l1_fill_data, l1_fill_valid, l1_fill_from_vc, busy,
        output mem_address, vc_read, vc_write,
        output mem_wdata, is_mem_wdata_dirty,
        input  vc_vcmem_rdata256, rdata_exists,
        output pmem_read, pmem_address,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        output l1_miss_req, l1_evict, l1_miss_addr,
        output l1_victim_addr, l1_victim_data, l1_victim_dirty,
        input  l1_fill_data, l1_fill_valid, l1_fill_from_vc, busy,
        input  mem_address, vc_read, vc_write,
        input  mem_wdata, is_mem_wdata_dirty,
        output vc_vcmem_rdata256, rdata_exists,
        input  pmem_read, pmem_address,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/vc_req_timer.sv
// Per-state cycle timer: cleared on state entry, saturates at TIMEOUT-1.
// first_o marks the turnaround cycle, expire_o the response deadline.
module vc_req_timer #(
    parameter int TIMEOUT = 4,
    localparam int W = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic first_o,
    output logic expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and hold at the deadline.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (enable_i && !expire_o)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign first_o  = (cnt_q == '0);
    assign expire_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/l1_vc_requester.sv
// L1-side victim-cache initiator: probe VC, fall back to memory,
// write back the victim, then hand the fill line to L1.
module l1_vc_requester
    import vc_pkg::*;
#(
    parameter int VC_RESP_TIMEOUT = 4
) (
    input logic clk,
    input logic rst,
    l1_vc_requester_if.master bus
);

    l1vc_state_t state_q, state_d;
    addr_t miss_addr_q, victim_addr_q;
    line_t victim_data_q, fill_q;
    logic  evict_q, dirty_q, from_vc_q;
    logic  latch_req, ld_vc, ld_pm;
    logic  tmr_clr, tmr_first, tmr_expire;

    vc_req_timer #(
        .TIMEOUT (VC_RESP_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmr_clr),
        .enable_i (1'b1),
        .first_o  (tmr_first),
        .expire_o (tmr_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and latch strobes; responses in a state's first cycle are ignored.
    always_comb begin
        state_d   = state_q;
        latch_req = 1'b0;
        ld_vc     = 1'b0;
        ld_pm     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.l1_miss_req) begin
                    latch_req = 1'b1;
                    state_d   = VC_RD;
                end
            end
            VC_RD: begin
                if (bus.rdata_exists && !tmr_first) begin
                    ld_vc   = 1'b1;
                    state_d = evict_q ? VC_WR : FILL;
                end else if (tmr_expire) begin
                    state_d = PMEM_RD;
                end
            end
            PMEM_RD: begin
                if (bus.pmem_resp) begin
                    ld_pm   = 1'b1;
                    state_d = evict_q ? VC_WR : FILL;
                end
            end
            VC_WR: begin
                if (bus.rdata_exists && !tmr_first)
                    state_d = FILL;
            end
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign tmr_clr = (state_d != state_q);

    // Request and fill-line latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
            evict_q       <= 1'b0;
            dirty_q       <= 1'b0;
            fill_q        <= '0;
            from_vc_q     <= 1'b0;
        end else begin
            if (latch_req) begin
                miss_addr_q   <= bus.l1_miss_addr;
                victim_addr_q <= bus.l1_victim_addr;
                victim_data_q <= bus.l1_victim_data;
                evict_q       <= bus.l1_evict;
                dirty_q       <= bus.l1_victim_dirty;
            end
            if (ld_vc) begin
                fill_q    <= bus.vc_vcmem_rdata256;
                from_vc_q <= 1'b1;
            end else if (ld_pm) begin
                fill_q    <= bus.pmem_rdata;
                from_vc_q <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.vc_read   = (state_q == VC_RD);
    assign bus.vc_write  = (state_q == VC_WR);
    assign bus.pmem_read = (state_q == PMEM_RD);

    assign bus.mem_address =
        (state_q == VC_RD) ? align_line(miss_addr_q) :
        (state_q == VC_WR) ? align_line(victim_addr_q) : '0;

    assign bus.pmem_address =
        (state_q == PMEM_RD) ? align_line(miss_addr_q) : '0;

    assign bus.mem_wdata          = (state_q == VC_WR) ? victim_data_q : '0;
    assign bus.is_mem_wdata_dirty = (state_q == VC_WR) && dirty_q;

    assign bus.l1_fill_valid   = (state_q == FILL);
    assign bus.l1_fill_data    = (state_q == FILL) ? fill_q : '0;
    assign bus.l1_fill_from_vc = (state_q == FILL) && from_vc_q;

endmodule

// File: tb/tb_l1_vc_requester.sv
// Scoreboard bench for l1_vc_requester: expected fills are queued
// when responses are driven and compared when the fill pulse appears.
module tb_l1_vc_requester;
    import vc_pkg::*;

    typedef struct packed {
        line_t d;
        logic  v;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   n_fill;
    int   n_vcrd;
    int   n_pmrd;
    exp_t sb[$];

    l1_vc_requester_if bus();

    l1_vc_requester #(
        .VC_RESP_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: scoreboard pops on fill, exclusivity and request counters.
    always @(negedge clk) begin
        if (rst) begin
            check("rd_wr_excl", 256'(bus.vc_read & bus.vc_write), '0);
            if (bus.vc_read) n_vcrd++;
            if (bus.pmem_read) n_pmrd++;
            if (bus.l1_fill_valid) begin
                n_fill++;
                if (sb.size() == 0) begin
                    check("fill_unexp", 256'(1), '0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("fill_data", bus.l1_fill_data, e.d);
                    check("fill_from_vc", 256'(bus.l1_fill_from_vc), 256'(e.v));
                end
            end
        end
    end

    initial begin
        int f0, v0, p0;
        line_t da, db;
        n_vec = 0; n_err = 0; n_fill = 0; n_vcrd = 0; n_pmrd = 0;
        rst = 1'b0;
        bus.l1_miss_req = 0; bus.l1_evict = 0;
        bus.l1_miss_addr = '0; bus.l1_victim_addr = '0;
        bus.l1_victim_data = '0; bus.l1_victim_dirty = 0;
        bus.vc_vcmem_rdata256 = '0; bus.rdata_exists = 0;
        bus.pmem_rdata = '0; bus.pmem_resp = 0;
        cyc(3);
        check("rst_busy", 256'(bus.busy), '0);
        check("rst_fill_valid", 256'(bus.l1_fill_valid), '0);
        rst = 1'b1;
        cyc(2);

        // Asynchronous reset in the middle of a probe.
        bus.l1_miss_req = 1; bus.l1_miss_addr = 32'h0000_0040;
        cyc(1);
        check("pre_rst_vc_read", 256'(bus.vc_read), 256'(1));
        f0 = n_fill;
        rst = 1'b0;
        #1;
        check("arst_vc_read", 256'(bus.vc_read), '0);
        check("arst_busy", 256'(bus.busy), '0);
        check("arst_mem_address", bus.mem_address, '0);
        cyc(2);
        bus.l1_miss_req = 0;
        rst = 1'b1;
        cyc(3);
        check("post_rst_busy", 256'(bus.busy), '0);
        check("post_rst_no_fill", n_fill - f0, '0);

        // VC hit, no evict; L1 address changes during the probe are ignored.
        p0 = n_pmrd;
        da = {32{8'hA5}};
        bus.l1_miss_req = 1; bus.l1_evict = 0;
        bus.l1_miss_addr = 32'h0000_1234;
        cyc(1);
        check("hit_vc_read", 256'(bus.vc_read), 256'(1));
        check("hit_mem_addr", bus.mem_address, 32'h0000_1220);
        bus.l1_miss_addr = 32'hFFFF_FFFF;
        cyc(1);
        check("hit_addr_held", bus.mem_address, 32'h0000_1220);
        bus.rdata_exists = 1; bus.vc_vcmem_rdata256 = da;
        sb.push_back('{d: da, v: 1'b1});
        cyc(1);
        bus.rdata_exists = 0;
        check("hit_fill_c3", 256'(bus.l1_fill_valid), 256'(1));
        bus.l1_miss_req = 0;
        cyc(1);
        check("hit_idle", 256'(bus.busy), '0);
        check("hit_no_pmem", n_pmrd - p0, '0);

        // VC miss, dirty evict: timeout, memory read, victim write.
        v0 = n_vcrd; p0 = n_pmrd;
        db = {8{32'hDEAD_BEEF}};
        da = {16{16'h5AC3}};
        bus.l1_miss_req = 1; bus.l1_evict = 1;
        bus.l1_miss_addr = 32'h0000_5678;
        bus.l1_victim_addr = 32'h0000_8045;
        bus.l1_victim_data = da; bus.l1_victim_dirty = 1;
        cyc(5);
        check("miss_pmem_read", 256'(bus.pmem_read), 256'(1));
        check("miss_pmem_addr", bus.pmem_address, 32'h0000_5660);
        check("miss_vc_rd_cycles", n_vcrd - v0, 256'(4));
        cyc(4);
        bus.pmem_resp = 1; bus.pmem_rdata = db;
        sb.push_back('{d: db, v: 1'b0});
        cyc(1);
        bus.pmem_resp = 0;
        check("miss_pmem_cycles", n_pmrd - p0, 256'(5));
        check("wr_vc_write", 256'(bus.vc_write), 256'(1));
        check("wr_addr", bus.mem_address, 32'h0000_8040);
        check("wr_data", bus.mem_wdata, da);
        check("wr_dirty", 256'(bus.is_mem_wdata_dirty), 256'(1));
        cyc(1);
        bus.rdata_exists = 1;
        cyc(1);
        bus.rdata_exists = 0;
        check("miss_fill", 256'(bus.l1_fill_valid), 256'(1));
        bus.l1_miss_req = 0; bus.l1_evict = 0; bus.l1_victim_dirty = 0;
        cyc(2);

        // Late VC response during the memory read is discarded.
        da = {4{64'h0123_4567_89AB_CDEF}};
        db = {8{32'hCAFE_F00D}};
        bus.l1_miss_req = 1; bus.l1_miss_addr = 32'h0000_ABC0;
        cyc(5);
        check("late_pmem_read", 256'(bus.pmem_read), 256'(1));
        bus.rdata_exists = 1; bus.vc_vcmem_rdata256 = da;
        cyc(1);
        bus.rdata_exists = 0;
        check("late_still_pmem", 256'(bus.pmem_read), 256'(1));
        bus.pmem_resp = 1; bus.pmem_rdata = db;
        sb.push_back('{d: db, v: 1'b0});
        cyc(1);
        bus.pmem_resp = 0;
        check("late_fill", 256'(bus.l1_fill_valid), 256'(1));
        bus.l1_miss_req = 0;
        cyc(2);

        // Turnaround guard with rdata_exists held high.
        da = {32{8'h3C}};
        bus.rdata_exists = 1; bus.vc_vcmem_rdata256 = da;
        bus.l1_miss_req = 1; bus.l1_evict = 1;
        bus.l1_miss_addr = 32'h0000_0F00;
        bus.l1_victim_addr = 32'h0000_2020;
        sb.push_back('{d: da, v: 1'b1});
        cyc(1);
        check("ta_rd_c1", 256'(bus.vc_read), 256'(1));
        cyc(1);
        check("ta_rd_c2", 256'(bus.vc_read), 256'(1));
        cyc(1);
        check("ta_wr_c1", 256'(bus.vc_write), 256'(1));
        check("ta_wr_addr", bus.mem_address, 32'h0000_2020);
        cyc(1);
        check("ta_wr_c2", 256'(bus.vc_write), 256'(1));
        cyc(1);
        check("ta_fill", 256'(bus.l1_fill_valid), 256'(1));
        bus.l1_miss_req = 0; bus.l1_evict = 0;
        cyc(1);

        // Back-to-back: request held through the fill, then a new address.
        f0 = n_fill;
        da = {8{32'h1111_2222}};
        db = {8{32'h3333_4444}};
        bus.vc_vcmem_rdata256 = da;
        bus.l1_miss_req = 1; bus.l1_miss_addr = 32'h0000_1000;
        sb.push_back('{d: da, v: 1'b1});
        cyc(3);
        check("b2b_fill_a", 256'(bus.l1_fill_valid), 256'(1));
        bus.l1_miss_addr = 32'h0000_2000;
        bus.vc_vcmem_rdata256 = db;
        sb.push_back('{d: db, v: 1'b1});
        cyc(1);
        check("b2b_idle_between", 256'(bus.busy), '0);
        cyc(1);
        check("b2b_addr_b", bus.mem_address, 32'h0000_2000);
        cyc(2);
        check("b2b_fill_b", 256'(bus.l1_fill_valid), 256'(1));
        bus.l1_miss_req = 0; bus.rdata_exists = 0;
        cyc(3);
        check("b2b_fill_count", n_fill - f0, 256'(2));
        check("sb_empty", 256'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
